// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and defaults for the fifo controller
package fifo_pkg;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_side_e;

    localparam int DEF_SIZE_ADDR = 3;

endpackage

// File: rtl/fifo_rr_arb.sv
// rtl/fifo_rr_arb.sv - two-way round-robin arbiter between write and read sides
module fifo_rr_arb
    import fifo_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    gnt_side_e last_gnt;

    // On contention the side that did not win last time gets the slot.
    always_comb begin
        o_gnt_wr = 1'b0;
        o_gnt_rd = 1'b0;
        if (!i_rst) begin
            if (i_req_wr && i_req_rd) begin
                if (last_gnt == GNT_RD) begin
                    o_gnt_wr = 1'b1;
                end else begin
                    o_gnt_rd = 1'b1;
                end
            end else begin
                o_gnt_wr = i_req_wr;
                o_gnt_rd = i_req_rd;
            end
        end
    end

    // Reset to read so that the first contended cycle favours the writer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_gnt <= GNT_RD;
        end else if (o_gnt_wr) begin
            last_gnt <= GNT_WR;
        end else if (o_gnt_rd) begin
            last_gnt <= GNT_RD;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - fifo pointer, occupancy and flag controller for a single-port memory
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int SIZE_ADDR = DEF_SIZE_ADDR,
    parameter int DEPTH     = 2 ** SIZE_ADDR,
    parameter int AF_LEVEL  = DEPTH - 1,
    parameter int AE_LEVEL  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_req,
    output logic                 o_wr_ack,
    input  logic                 i_rd_req,
    output logic                 o_rd_ack,
    output logic                 o_mem_wr_en,
    output logic                 o_mem_rd_en,
    output logic [SIZE_ADDR-1:0] o_wr_addr,
    output logic [SIZE_ADDR-1:0] o_rd_addr,
    output logic                 o_rd_valid,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
    output logic [SIZE_ADDR:0]   o_count,
    output logic                 o_overflow,
    output logic                 o_underflow,
    input  logic                 i_clr_err
);

    localparam logic [SIZE_ADDR:0] DEPTH_C    = (SIZE_ADDR + 1)'(DEPTH);
    localparam logic [SIZE_ADDR:0] AF_C       = (SIZE_ADDR + 1)'(AF_LEVEL);
    localparam logic [SIZE_ADDR:0] AE_C       = (SIZE_ADDR + 1)'(AE_LEVEL);
    localparam logic [SIZE_ADDR:0] PTR_LAST   = (SIZE_ADDR + 1)'(2 * DEPTH - 1);
    localparam logic [SIZE_ADDR:0] ONE_C      = {{SIZE_ADDR{1'b0}}, 1'b1};

    logic [SIZE_ADDR:0] wr_ptr;
    logic [SIZE_ADDR:0] rd_ptr;
    logic               wr_ok;
    logic               rd_ok;
    logic               gnt_wr;
    logic               gnt_rd;

    assign o_full         = (o_count == DEPTH_C);
    assign o_empty        = (o_count == '0);
    assign o_almost_full  = (o_count >= AF_C);
    assign o_almost_empty = (o_count <= AE_C);

    assign wr_ok = i_wr_req & ~o_full;
    assign rd_ok = i_rd_req & ~o_empty;

    fifo_rr_arb u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req_wr (wr_ok),
        .i_req_rd (rd_ok),
        .o_gnt_wr (gnt_wr),
        .o_gnt_rd (gnt_rd)
    );

    assign o_wr_ack    = gnt_wr;
    assign o_mem_wr_en = gnt_wr;
    assign o_rd_ack    = gnt_rd;
    assign o_mem_rd_en = gnt_rd;

    assign o_wr_addr = wr_ptr[SIZE_ADDR-1:0];
    assign o_rd_addr = rd_ptr[SIZE_ADDR-1:0];

    // Pointers carry one extra bit and wrap at twice the depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (gnt_wr) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ONE_C;
            end
            if (gnt_rd) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + ONE_C;
            end
        end
    end

    // Grants are mutually exclusive, so occupancy moves by at most one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count <= '0;
        end else if (gnt_wr) begin
            o_count <= o_count + ONE_C;
        end else if (gnt_rd) begin
            o_count <= o_count - ONE_C;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= gnt_rd;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wr_req && o_full) begin
                o_overflow <= 1'b1;
            end else if (i_clr_err) begin
                o_overflow <= 1'b0;
            end
            if (i_rd_req && o_empty) begin
                o_underflow <= 1'b1;
            end else if (i_clr_err) begin
                o_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - scoreboard bench for fifo_ctrl with a queue-level reference model
module tb_fifo_ctrl;

    localparam int SA = 3;
    localparam int D  = 8;
    localparam int AF = 7;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          clr_err = 1'b0;
    logic          wr_ack, rd_ack, mem_wr_en, mem_rd_en, rd_valid;
    logic [SA-1:0] wr_addr, rd_addr;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [SA:0]   count;

    always #5 clk = ~clk;

    fifo_ctrl #(.SIZE_ADDR(SA), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_wr_req       (wr_req),
        .o_wr_ack       (wr_ack),
        .i_rd_req       (rd_req),
        .o_rd_ack       (rd_ack),
        .o_mem_wr_en    (mem_wr_en),
        .o_mem_rd_en    (mem_rd_en),
        .o_wr_addr      (wr_addr),
        .o_rd_addr      (rd_addr),
        .o_rd_valid     (rd_valid),
        .o_full         (full),
        .o_empty        (empty),
        .o_almost_full  (almost_full),
        .o_almost_empty (almost_empty),
        .o_count        (count),
        .o_overflow     (overflow),
        .o_underflow    (underflow),
        .i_clr_err      (clr_err)
    );

    typedef struct {
        int cnt;
        bit full, empty, af, ae, ovf, unf, rv, gw, gr;
        int wa, ra;
    } exp_t;

    exp_t st_q[$];
    int   wa_q[$];
    int   ra_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: slots held, total writes/reads, who won last, pending flags.
    int   m_items[$];
    int   m_wr_total = 0;
    int   m_rd_total = 0;
    bit   m_last_rd  = 1'b1;
    bit   m_rv = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_items.delete();
        m_wr_total = 0;
        m_rd_total = 0;
        m_last_rd  = 1'b1;
        m_rv = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic cycle(input bit r, input bit w, input bit rq, input bit c);
        exp_t e;
        bit   wok, rok, gw, gr;
        int   n;
        @(posedge clk);
        #1;
        rst = r; wr_req = w; rd_req = rq; clr_err = c;
        n   = m_items.size();
        wok = w && (n < D);
        rok = rq && (n > 0);
        gw  = 1'b0; gr = 1'b0;
        if (!r) begin
            if (wok && rok) begin
                gw = m_last_rd;
                gr = !m_last_rd;
            end else begin
                gw = wok;
                gr = rok;
            end
        end
        e.cnt = n; e.full = (n == D); e.empty = (n == 0);
        e.af = (n >= AF); e.ae = (n <= AE);
        e.ovf = m_ovf; e.unf = m_unf; e.rv = m_rv;
        e.gw = gw; e.gr = gr;
        e.wa = m_wr_total % D; e.ra = m_rd_total % D;
        st_q.push_back(e);
        if (gw) wa_q.push_back(m_wr_total % D);
        if (gr) ra_q.push_back(m_rd_total % D);
        if (r) begin
            model_reset();
        end else begin
            if (w && n == D) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
            if (rq && n == 0) m_unf = 1'b1; else if (c) m_unf = 1'b0;
            m_rv = gr;
            if (gw) begin
                m_items.push_back(m_wr_total % D);
                m_wr_total = (m_wr_total + 1) % (2 * D);
                m_last_rd = 1'b0;
            end
            if (gr) begin
                void'(m_items.pop_front());
                m_rd_total = (m_rd_total + 1) % (2 * D);
                m_last_rd = 1'b1;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("count", count, e.cnt);
                chk("full", full, e.full);
                chk("empty", empty, e.empty);
                chk("almost_full", almost_full, e.af);
                chk("almost_empty", almost_empty, e.ae);
                chk("overflow", overflow, e.ovf);
                chk("underflow", underflow, e.unf);
                chk("rd_valid", rd_valid, e.rv);
                chk("wr_ack", wr_ack, e.gw);
                chk("rd_ack", rd_ack, e.gr);
                chk("mem_wr_en", mem_wr_en, e.gw);
                chk("mem_rd_en", mem_rd_en, e.gr);
                chk("wr_addr", wr_addr, e.wa);
                chk("rd_addr", rd_addr, e.ra);
            end
            chk("enables_exclusive", mem_wr_en & mem_rd_en, 0);
            if (wr_ack === 1'b1) begin
                if (wa_q.size() == 0) chk("unexpected_wr_ack", 1, 0);
                else chk("wr_ack_addr", wr_addr, wa_q.pop_front());
            end
            if (rd_ack === 1'b1) begin
                if (ra_q.size() == 0) chk("unexpected_rd_ack", 1, 0);
                else chk("rd_ack_addr", rd_addr, ra_q.pop_front());
            end
        end
    end

    initial begin : stimulus
        int p_wr, p_rd;
        repeat (2) cycle(1, 1, 1, 0);
        repeat (9) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        repeat (9) cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        // Reach count 4 with a read as the last grant so contention starts with a write.
        cycle(1, 0, 0, 0);
        repeat (5) cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        repeat (6) cycle(0, 1, 1, 0);
        repeat (10) begin
            cycle(0, 1, 0, 0);
            cycle(0, 0, 1, 0);
        end
        cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        for (int ph = 0; ph < 8; ph++) begin
            p_wr = (ph % 2 == 0) ? 80 : 30;
            p_rd = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 50; i++) begin
                cycle(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < p_wr) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < p_rd) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0);
            end
        end
        cycle(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("state_q_drained", st_q.size(), 0);
        chk("wr_q_drained", wa_q.size(), 0);
        chk("rd_q_drained", ra_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
